// File: rtl/fpu_pkg.sv
// Shared FPU scheduler definitions.
// Op codes, highest valid op, scheduler state encoding.
package fpu_pkg;

  localparam int unsigned FPU_ADD    = 0;
  localparam int unsigned FPU_SUB    = 1;
  localparam int unsigned FPU_MUL    = 2;
  localparam int unsigned FPU_DIV    = 3;
  localparam int unsigned FPU_OP_MAX = 3;

  typedef enum logic [1:0] {
    SCH_IDLE,
    SCH_ISSUE,
    SCH_WAIT,
    SCH_RESPOND
  } sch_state_e;

endpackage

// File: rtl/fpu_rr_scheduler_if.sv
// Requester-side bus of the FPU scheduler.
// Packed per-port request operands/op, one-hot ready/valid, shared result.
interface fpu_rr_scheduler_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 8
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_lhs;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_rhs;
  logic [NUM_REQ*OP_WIDTH-1:0]   req_op;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [NUM_REQ-1:0]            rsp_ack;
  logic [DATA_WIDTH-1:0]         rsp_result;
  logic                          rsp_error;

  modport slave (
    input  req_valid, req_lhs, req_rhs,
    input  req_op, rsp_ack,
    output req_ready, rsp_valid,
    output rsp_result, rsp_error
  );

  modport master (
    output req_valid, req_lhs, req_rhs,
    output req_op, rsp_ack,
    input  req_ready, rsp_valid,
    input  rsp_result, rsp_error
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set req bit after ptr, wrapping.
// Ports: req_i, ptr_i in; one-hot grant_o, index idx_o, any_o out.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);

  logic [IW-1:0] j;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = IW'((int'(ptr_i) + k) % NUM_REQ);
      if (!any_o && req_i[j]) begin
        any_o      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = j;
      end
    end
  end

endmodule

// File: rtl/fpu_rr_scheduler.sv
// Round-robin sharing of one FPU op unit among NUM_REQ ports.
// Ports: Clock, Reset, requester bus (slave), FPU trigger/result side, busy.
module fpu_rr_scheduler
  import fpu_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 8,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                  Clock,
  input  logic                  Reset,
  fpu_rr_scheduler_if.slave     bus,
  output logic                  fpu_trigger,
  input  logic                  fpu_completed,
  output logic [DATA_WIDTH-1:0] fpu_lhs,
  output logic [DATA_WIDTH-1:0] fpu_rhs,
  output logic [OP_WIDTH-1:0]   fpu_op,
  input  logic [DATA_WIDTH-1:0] fpu_result,
  output logic                  busy
);

  sch_state_e            state_q;
  logic [IW-1:0]         ptr_q;
  logic [IW-1:0]         gidx_q;
  logic [IW-1:0]         gidx;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    dec;
  logic                  any;
  logic                  ack_hit;
  logic [DATA_WIDTH-1:0] lhs_sel;
  logic [DATA_WIDTH-1:0] rhs_sel;
  logic [OP_WIDTH-1:0]   op_sel;
  logic [DATA_WIDTH-1:0] lhs_q;
  logic [DATA_WIDTH-1:0] rhs_q;
  logic [DATA_WIDTH-1:0] res_q;
  logic [OP_WIDTH-1:0]   op_q;
  logic                  err_q;
  logic                  trig_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i   (bus.req_valid),
    .ptr_i   (ptr_q),
    .grant_o (gnt),
    .idx_o   (gidx),
    .any_o   (any)
  );

  always_comb begin
    lhs_sel = '0;
    rhs_sel = '0;
    op_sel  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        lhs_sel = bus.req_lhs[i*DATA_WIDTH +: DATA_WIDTH];
        rhs_sel = bus.req_rhs[i*DATA_WIDTH +: DATA_WIDTH];
        op_sel  = bus.req_op[i*OP_WIDTH +: OP_WIDTH];
      end
    end
  end

  always_comb begin
    dec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      dec[i] = (gidx_q == IW'(i));
    end
  end

  // Only the granted port's ack can close the response.
  assign ack_hit = |(bus.rsp_ack & dec);

  assign bus.req_ready  = (state_q == SCH_IDLE) ? gnt : '0;
  assign bus.rsp_valid  = (state_q == SCH_RESPOND) ? dec : '0;
  assign bus.rsp_result = res_q;
  assign bus.rsp_error  = err_q;
  assign fpu_trigger    = trig_q;
  assign fpu_lhs        = lhs_q;
  assign fpu_rhs        = rhs_q;
  assign fpu_op         = op_q;
  assign busy           = (state_q != SCH_IDLE);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= SCH_IDLE;
      ptr_q   <= IW'(NUM_REQ - 1);
      gidx_q  <= '0;
      lhs_q   <= '0;
      rhs_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      unique case (state_q)
        SCH_IDLE: begin
          if (any) begin
            lhs_q  <= lhs_sel;
            rhs_q  <= rhs_sel;
            op_q   <= op_sel;
            gidx_q <= gidx;
            ptr_q  <= gidx;
            if (op_sel > OP_WIDTH'(FPU_OP_MAX)) begin
              err_q   <= 1'b1;
              res_q   <= '0;
              state_q <= SCH_RESPOND;
            end else begin
              err_q   <= 1'b0;
              trig_q  <= 1'b1;
              state_q <= SCH_ISSUE;
            end
          end
        end
        SCH_ISSUE: begin
          trig_q  <= 1'b0;
          state_q <= SCH_WAIT;
        end
        SCH_WAIT: begin
          if (fpu_completed) begin
            res_q   <= fpu_result;
            state_q <= SCH_RESPOND;
          end
        end
        SCH_RESPOND: begin
          if (ack_hit) begin
            state_q <= SCH_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_rr_scheduler.sv
// Testbench for fpu_rr_scheduler: FPU stub, transaction model,
// directed scenarios and a randomized run.
module tb_fpu_rr_scheduler;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fpu_rr_scheduler_if #(
    .NUM_REQ(N), .DATA_WIDTH(32), .OP_WIDTH(8)
  ) bus ();

  logic        trig;
  logic        comp = 1'b0;
  logic        busy;
  logic [31:0] flhs, frhs;
  logic [31:0] fres = '0;
  logic [7:0]  fop;

  logic [31:0] lhs_a [N];
  logic [31:0] rhs_a [N];
  logic [7:0]  op_a  [N];

  assign bus.req_lhs = {lhs_a[3], lhs_a[2], lhs_a[1], lhs_a[0]};
  assign bus.req_rhs = {rhs_a[3], rhs_a[2], rhs_a[1], rhs_a[0]};
  assign bus.req_op  = {op_a[3], op_a[2], op_a[1], op_a[0]};

  fpu_rr_scheduler #(
    .NUM_REQ(N), .DATA_WIDTH(32), .OP_WIDTH(8)
  ) dut (
    .Clock         (clk),
    .Reset         (rst),
    .bus           (bus),
    .fpu_trigger   (trig),
    .fpu_completed (comp),
    .fpu_lhs       (flhs),
    .fpu_rhs       (frhs),
    .fpu_op        (fop),
    .fpu_result    (fres),
    .busy          (busy)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // FPU stub: known IEEE vectors, otherwise an arbitrary mix.
  function automatic logic [31:0] fpu_calc(
    input logic [31:0] a, input logic [31:0] b,
    input logic [7:0] op);
    if (a == 32'h3F800000 && b == 32'h40000000 && op == 8'd0)
      return 32'h40400000;
    if (a == 32'h40C00000 && b == 32'h40000000 && op == 8'd3)
      return 32'h40400000;
    return a ^ {b[15:0], b[31:16]} ^ {24'h0, op} ^ 32'h5A5A0000;
  endfunction

  int          lat_cfg = 3;
  bit          stray   = 1'b0;
  int          cnt     = 0;
  logic [31:0] f_a, f_b;
  logic [7:0]  f_op;

  always begin
    @(posedge clk);
    #1;
    comp = 1'b0;
    if (rst) begin
      cnt = 0;
    end else if (trig) begin
      cnt  = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(20, 1));
      f_a  = flhs;
      f_b  = frhs;
      f_op = fop;
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        comp = 1'b1;
        fres = fpu_calc(f_a, f_b, f_op);
      end
    end else if (stray) begin
      comp = 1'b1;
      fres = 32'hDEADBEEF;
    end
  end

  // Transaction-level model of the scheduler.
  int          m_ptr = N - 1;
  bit          m_busy, m_trig, m_wait, m_done, m_err;
  int          m_port;
  logic [31:0] m_lhs, m_rhs, m_res;
  logic [7:0]  m_op;
  int          acc_q [$];
  int          trig_cnt = 0;
  int          g;
  logic [3:0]  er, ev;

  function automatic int rr_pick(input logic [3:0] v, input int p);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (p + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      m_ptr  = N - 1;
      m_busy = 0;
      m_trig = 0;
      m_wait = 0;
      m_done = 0;
    end else begin
      g  = m_busy ? -1 : rr_pick(bus.req_valid, m_ptr);
      er = (g < 0) ? 4'd0 : 4'(1 << g);
      chk("req_ready", 32'(bus.req_ready), 32'(er));
      chk("ready_onehot", 32'($onehot0(bus.req_ready)), 32'd1);
      chk("trigger", 32'(trig), 32'(m_trig));
      ev = (m_busy && m_done) ? 4'(1 << m_port) : 4'd0;
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(ev));
      chk("busy", 32'(busy), 32'(m_busy));
      if (m_busy && m_done) begin
        chk("rsp_result", bus.rsp_result, m_res);
        chk("rsp_error", 32'(bus.rsp_error), 32'(m_err));
      end
      if (m_busy) begin
        chk("fpu_lhs", flhs, m_lhs);
        chk("fpu_rhs", frhs, m_rhs);
        chk("fpu_op", 32'(fop), 32'(m_op));
      end
      if (trig) trig_cnt++;
      if (g >= 0) begin
        m_busy = 1;
        m_port = g;
        m_ptr  = g;
        m_lhs  = lhs_a[g];
        m_rhs  = rhs_a[g];
        m_op   = op_a[g];
        m_wait = 0;
        acc_q.push_back(g);
        if (op_a[g] > 8'd3) begin
          m_err  = 1;
          m_res  = '0;
          m_done = 1;
          m_trig = 0;
        end else begin
          m_err  = 0;
          m_done = 0;
          m_trig = 1;
        end
      end else if (m_busy) begin
        if (m_trig) begin
          m_trig = 0;
          m_wait = 1;
        end else if (m_wait && comp) begin
          m_res  = fres;
          m_done = 1;
          m_wait = 0;
        end else if (m_done && bus.rsp_ack[m_port]) begin
          m_busy = 0;
          m_done = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input string nm);
    for (int i = 0; i < 100 && !busy; i++) tick();
    chk(nm, 32'(busy), 32'd1);
  endtask

  task automatic wait_rsp(input int p, input string nm);
    for (int i = 0; i < 100 && !bus.rsp_valid[p]; i++) tick();
    chk(nm, 32'(bus.rsp_valid), 32'(1 << p));
  endtask

  task automatic ack(input int p);
    bus.rsp_ack = 4'(1 << p);
    tick();
    bus.rsp_ack = '0;
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    tick();
    tick();
    #2;
    rst = 1'b0;
    tick();
  endtask

  int          t0, n0;
  logic [31:0] r;

  initial begin
    bus.req_valid = '0;
    bus.rsp_ack   = '0;
    for (int i = 0; i < N; i++) begin
      lhs_a[i] = '0;
      rhs_a[i] = '0;
      op_a[i]  = '0;
    end
    #2;
    rst = 1'b1;
    #2;
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rspv", 32'(bus.rsp_valid), 32'd0);
    chk("rst_result", bus.rsp_result, 32'd0);
    chk("rst_error", 32'(bus.rsp_error), 32'd0);
    chk("rst_trig", 32'(trig), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_lhs", flhs, 32'd0);
    chk("rst_op", 32'(fop), 32'd0);
    tick();
    #2;
    rst = 1'b0;
    tick();

    // 1: single add on port 2
    t0 = trig_cnt;
    lat_cfg = 3;
    lhs_a[2] = 32'h3F800000;
    rhs_a[2] = 32'h40000000;
    op_a[2]  = 8'd0;
    bus.req_valid = 4'b0100;
    tick();
    wait_busy("t1_accept");
    bus.req_valid = '0;
    wait_rsp(2, "t1_rspv");
    chk("t1_result", bus.rsp_result, 32'h40400000);
    chk("t1_trigs", 32'(trig_cnt - t0), 32'd1);
    ack(2);
    tick();

    // 3: invalid op on port 1
    t0 = trig_cnt;
    op_a[1] = 8'd7;
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = '0;
    chk("t3_busy", 32'(busy), 32'd1);
    chk("t3_rspv", 32'(bus.rsp_valid), 32'h2);
    chk("t3_error", 32'(bus.rsp_error), 32'd1);
    chk("t3_result", bus.rsp_result, 32'd0);
    tick();
    tick();
    chk("t3_notrig", 32'(trig_cnt - t0), 32'd0);
    ack(1);
    tick();

    // 4: held ack, port 0 waits
    lat_cfg = 2;
    lhs_a[3] = 32'h40400000;
    rhs_a[3] = 32'h40000000;
    op_a[3]  = 8'd2;
    bus.req_valid = 4'b1000;
    tick();
    wait_busy("t4_accept");
    lhs_a[0] = 32'h12345678;
    rhs_a[0] = 32'h0BADF00D;
    op_a[0]  = 8'd1;
    bus.req_valid = 4'b0001;
    wait_rsp(3, "t4_rspv");
    r = bus.rsp_result;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_stable", bus.rsp_result, r);
      chk("t4_noready", 32'(bus.req_ready), 32'd0);
    end
    ack(3);
    tick();
    wait_busy("t4_accept0");
    chk("t4_grant0", 32'(acc_q[$]), 32'd0);
    bus.req_valid = '0;
    wait_rsp(0, "t4_rspv0");
    ack(0);
    tick();

    // 5: reset while waiting on the FPU
    lat_cfg = 20;
    lhs_a[2] = 32'hCAFEF00D;
    op_a[2]  = 8'd0;
    bus.req_valid = 4'b0100;
    tick();
    wait_busy("t5_accept");
    bus.req_valid = '0;
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_rspv", 32'(bus.rsp_valid), 32'd0);
    chk("t5_ready", 32'(bus.req_ready), 32'd0);
    chk("t5_trig", 32'(trig), 32'd0);
    chk("t5_lhs", flhs, 32'd0);
    chk("t5_rhs", frhs, 32'd0);
    chk("t5_op", 32'(fop), 32'd0);
    chk("t5_result", bus.rsp_result, 32'd0);
    chk("t5_error", 32'(bus.rsp_error), 32'd0);
    tick();
    tick();
    #2;
    rst = 1'b0;
    tick();
    lat_cfg = 4;
    lhs_a[1] = 32'h3F800000;
    rhs_a[1] = 32'h40000000;
    op_a[1]  = 8'd0;
    bus.req_valid = 4'b0010;
    tick();
    wait_busy("t5_accept1");
    chk("t5_grant1", 32'(acc_q[$]), 32'd1);
    bus.req_valid = '0;
    wait_rsp(1, "t5_rspv1");
    chk("t5_result1", bus.rsp_result, 32'h40400000);
    ack(1);
    tick();

    // 6: div with stray completions and wrong-port acks
    lat_cfg = 5;
    stray = 1'b1;
    tick();
    tick();
    tick();
    stray = 1'b0;
    tick();
    lhs_a[0] = 32'h40C00000;
    rhs_a[0] = 32'h40000000;
    op_a[0]  = 8'd3;
    bus.req_valid = 4'b0001;
    tick();
    wait_busy("t6_accept");
    bus.req_valid = '0;
    bus.rsp_ack = 4'b1110;
    wait_rsp(0, "t6_rspv");
    stray = 1'b1;
    tick();
    tick();
    tick();
    chk("t6_rspv_held", 32'(bus.rsp_valid), 32'h1);
    chk("t6_result", bus.rsp_result, 32'h40400000);
    stray = 1'b0;
    bus.rsp_ack = '0;
    ack(0);
    tick();

    // 2: all ports request, immediate ack
    do_reset();
    lat_cfg = 1;
    for (int i = 0; i < N; i++) op_a[i] = 8'(i);
    bus.rsp_ack = 4'hF;
    n0 = acc_q.size();
    bus.req_valid = 4'hF;
    for (int i = 0; i < 300 && acc_q.size() < n0 + 6; i++) tick();
    chk("t2_count", 32'(acc_q.size() >= n0 + 6), 32'd1);
    for (int k = 0; k < 6; k++) begin
      if (acc_q.size() > n0 + k)
        chk("t2_order", 32'(acc_q[n0+k]), 32'(k % N));
    end
    bus.req_valid = '0;
    repeat (20) tick();
    bus.rsp_ack = '0;

    // randomized run
    lat_cfg = 0;
    repeat (3000) begin
      bus.req_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        lhs_a[i] = $urandom;
        rhs_a[i] = $urandom;
        if ($urandom_range(0, 9) == 0)
          op_a[i] = 8'($urandom_range(4, 255));
        else
          op_a[i] = 8'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 2) == 0)
        bus.rsp_ack = 4'($urandom);
      else
        bus.rsp_ack = '0;
      stray = ($urandom_range(0, 19) == 0);
      tick();
    end
    stray = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ack = 4'hF;
    repeat (40) tick();
    chk("final_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
